// File: rtl/fft_input_loader.sv
// fft_input_loader: streams complex samples into the shared FFT sample RAM at
// bit-reversed addresses, kicks the in-place engine and reports frame completion.
module fft_input_loader #(
  parameter int BIT_WIDTH = 8,
  parameter int MODE_NUM  = 3,
  parameter int FFT_SIZE  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(MODE_NUM)-1:0]   mode,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [BIT_WIDTH-1:0]          in_re,
  input  logic [BIT_WIDTH-1:0]          in_im,
  output logic                          in_ready,
  output logic                          mem_wr_en,
  output logic [$clog2(FFT_SIZE)-1:0]   mem_addr,
  output logic [2*BIT_WIDTH-1:0]        mem_data,
  output logic                          mem_owner,
  output logic                          fft_init,
  input  logic                          fft_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int MW = $clog2(MODE_NUM);
  localparam int AW = $clog2(FFT_SIZE);
  localparam int CW = AW + 1;
  localparam logic [MW-1:0] MODE_MAX = MW'(MODE_NUM - 1);

  typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT, DONE} state_t;

  state_t        state;
  logic [MW-1:0] mode_l;
  logic [CW-1:0] cnt;
  logic [CW-1:0] n_pts;
  logic          ready_hist;
  logic [AW-1:0] rev_full;
  logic [AW-1:0] rev_addr;
  logic          accept;

  // Frame length, ready/accept handshake and L-bit reversal of the sample counter.
  // The full-width reversal is shifted down so only the low L = mode_l+2 bits
  // carry the reversed index and the upper bits are zero.
  always_comb begin
    n_pts    = CW'(4) << mode_l;
    in_ready = (state == LOAD) && (cnt != n_pts);
    accept   = in_valid && in_ready;
    rev_full = '0;
    for (int unsigned i = 0; i < AW; i++) begin
      rev_full[i] = cnt[AW-1-i];
    end
    rev_addr = rev_full >> (AW - 2 - int'(mode_l));
  end

  // Frame sequencer with registered RAM-port, engine and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mode_l     <= '0;
      cnt        <= '0;
      ready_hist <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_owner  <= 1'b1;
      fft_init   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      fft_init  <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD;
            cnt    <= '0;
            busy   <= 1'b1;
            mode_l <= (mode > MODE_MAX) ? MODE_MAX : mode;
          end
        end
        LOAD: begin
          if (accept) begin
            mem_wr_en <= 1'b1;
            mem_addr  <= rev_addr;
            mem_data  <= {in_re, in_im};
            cnt       <= cnt + CW'(1);
          end else if (cnt == n_pts) begin
            // Final write is on the port this cycle; hand the RAM to the engine.
            state     <= KICK;
            mem_owner <= 1'b0;
            fft_init  <= 1'b1;
          end
        end
        KICK: begin
          ready_hist <= fft_ready;
          state      <= WAIT;
        end
        WAIT: begin
          ready_hist <= fft_ready;
          if (fft_ready && !ready_hist) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mem_owner <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Scoreboard bench for fft_input_loader: stimulus pushes expected RAM writes,
// init and done events; a negedge monitor pops and compares them.
module tb_fft_input_loader;

  localparam int BW = 8;
  localparam int MN = 3;
  localparam int FS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = '0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_re = '0;
  logic [7:0]  in_im = '0;
  logic        fft_ready = 1'b0;
  logic        in_ready, mem_wr_en, mem_owner, fft_init, busy, done;
  logic [3:0]  mem_addr;
  logic [15:0] mem_data;

  int cyc  = 0;
  int nchk = 0;
  int nerr = 0;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t wr_q[$];
  int  init_q[$];
  int  done_q[$];

  fft_input_loader #(.BIT_WIDTH(BW), .MODE_NUM(MN), .FFT_SIZE(FS)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start),
    .in_valid(in_valid), .in_re(in_re), .in_im(in_im), .in_ready(in_ready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_owner(mem_owner), .fft_init(fft_init), .fft_ready(fft_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s: got 1 expected 0 (cycle %0d)", name, cyc);
  endtask

  // Reference bit reversal: read index bits LSB-first, build result MSB-first.
  function automatic int bitrev(input int k, input int nbits);
    int r = 0;
    int x = k;
    for (int i = 0; i < nbits; i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  wr_t e;
  int  ec;

  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (wr_q.size() == 0) fail("unexpected_write");
      else begin
        e = wr_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_data), 32'(e.data));
        chk("wr_cycle", cyc, e.cyc);
        chk("owner_on_write", 32'(mem_owner), 1);
      end
    end
    if (fft_init) begin
      if (init_q.size() == 0) fail("unexpected_fft_init");
      else begin
        ec = init_q.pop_front();
        chk("init_cycle", cyc, ec);
        chk("owner_on_init", 32'(mem_owner), 0);
      end
    end
    if (done) begin
      if (done_q.size() == 0) fail("unexpected_done");
      else begin
        ec = done_q.pop_front();
        chk("done_cycle", cyc, ec);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_load();
    mode = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_re = 8'($urandom);
      in_im = 8'($urandom);
      chk("in_ready_pre_reset", 32'(in_ready), 1);
      if (in_ready) wr_q.push_back('{addr: 4'(bitrev(k, 3)), data: {in_re, in_im}, cyc: cyc + 1});
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_owner", 32'(mem_owner), 1);
    chk("rst_addr", 32'(mem_addr), 0);
    tick();
    rst = 1'b1;
    tick();
  endtask

  // bub: 0 back-to-back, 1 fixed 1,0,1,1,0,1 pattern, 2 random bubbles.
  task automatic frame(input int md, input int bub, input bit det, input bit stale);
    int ml = (md > 2) ? 2 : md;
    int n  = 4 << ml;
    int nb = ml + 2;
    int k = 0, a = 0, budget = 0, pi = 0, t = 0;
    bit v;
    bit [5:0] pat = 6'b101101;
    fft_ready = stale;
    mode = 2'(md);
    start = 1'b1;
    in_valid = 1'b1;
    in_re = 8'hAA;
    in_im = 8'h55;
    chk("in_ready_idle", 32'(in_ready), 0);
    tick();
    start = 1'b0;
    chk("busy_load", 32'(busy), 1);
    while (k < n && budget < 400) begin
      case (bub)
        0:       v = 1'b1;
        1:       begin v = pat[pi % 6]; pi++; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      // start during a bubble must be ignored while busy
      start = !v;
      mode = 2'($urandom_range(0, 3));
      if (det) begin
        in_re = 8'(k);
        in_im = 8'(n - k);
      end else begin
        in_re = 8'($urandom);
        in_im = 8'($urandom);
      end
      if (v) begin
        chk("in_ready_load", 32'(in_ready), 1);
        if (in_ready) begin
          wr_q.push_back('{addr: 4'(bitrev(k, nb)), data: {in_re, in_im}, cyc: cyc + 1});
          a = cyc;
          k++;
        end
      end
      tick();
      budget++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (k < n) fail("load_timeout");
    init_q.push_back(a + 2);
    chk("in_ready_drain", 32'(in_ready), 0);
    tick();
    chk("owner_kick", 32'(mem_owner), 0);
    tick();
    start = 1'b1;
    mode = 2'd0;
    tick();
    start = 1'b0;
    if (stale) begin
      for (int i = 0; i < 3; i++) begin
        chk("no_done_stale", 32'(done), 0);
        tick();
      end
    end
    fft_ready = 1'b0;
    tick();
    chk("owner_wait", 32'(mem_owner), 0);
    tick();
    fft_ready = 1'b1;
    t = cyc;
    done_q.push_back(t + 1);
    tick();
    chk("busy_done", 32'(busy), 1);
    chk("owner_done", 32'(mem_owner), 0);
    tick();
    chk("busy_idle", 32'(busy), 0);
    chk("owner_idle", 32'(mem_owner), 1);
    chk("in_ready_idle_after", 32'(in_ready), 0);
    fft_ready = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_wr_en", 32'(mem_wr_en), 0);
    chk("reset_owner", 32'(mem_owner), 1);
    chk("reset_init", 32'(fft_init), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_addr", 32'(mem_addr), 0);
    chk("reset_data", 32'(mem_data), 0);
    rst = 1'b1;
    tick();
    reset_mid_load();
    frame(1, 0, 1'b1, 1'b1);
    frame(0, 1, 1'b1, 1'b0);
    frame(3, 0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      frame(int'($urandom_range(0, 3)), 2, 1'b0, 1'($urandom_range(0, 1)));
    end
    repeat (4) tick();
    chk("writes_outstanding", wr_q.size(), 0);
    chk("inits_outstanding", init_q.size(), 0);
    chk("dones_outstanding", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
